// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath and display stage:
// bus width, wrap limits and run-state encoding.
package stopwatch_pkg;

    localparam int unsigned SW_CNT_W   = 6;
    localparam int unsigned SW_MAX_SEC = 59;
    localparam int unsigned SW_MAX_MIN = 59;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } sw_state_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses/levels into the stopwatch core and the time/status buses out of it.
interface stopwatch_counter_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned CNT_W = SW_CNT_W
) ();

    logic             tick_1hz;
    logic             tick_2hz;
    logic             pause_pulse;
    logic             clear_pulse;
    logic             adj;
    logic             sel;
    logic [CNT_W-1:0] min;
    logic [CNT_W-1:0] sec;
    logic             running;
    logic             rollover;

    modport master (
        output tick_1hz, tick_2hz, pause_pulse, clear_pulse, adj, sel,
        input  min, sec, running, rollover
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_pulse, clear_pulse, adj, sel,
        output min, sec, running, rollover
    );

endinterface

// File: rtl/stopwatch_counter_wrap.sv
// Modulo (max+1) up-counter with synchronous clear; wrap is an explicit compare to max.
module wrap_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         at_max
);

    logic [W-1:0] r_value;
    logic         w_at_max;

    assign w_at_max = (r_value == max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= w_at_max ? '0 : r_value + 1'b1;
        end
    end

    assign value  = r_value;
    assign at_max = w_at_max;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: RUN/PAUSED FSM, clear/adjust/count priority mux,
// seconds and minutes wrap counters and the rollover pulse.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CNT_W   = SW_CNT_W,
    parameter int unsigned MAX_SEC = SW_MAX_SEC,
    parameter int unsigned MAX_MIN = SW_MAX_MIN
) (
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_counter_if.slave  bus
);

    sw_state_t        r_state;
    sw_state_t        w_state_nxt;
    logic             r_rollover;

    logic             w_count;
    logic             w_clr;
    logic             w_sec_inc;
    logic             w_min_inc;
    logic [CNT_W-1:0] w_sec;
    logic [CNT_W-1:0] w_min;
    logic             w_sec_at_max;
    logic             w_min_at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.pause_pulse) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Count qualification uses the pre-toggle state, so a pause landing with a tick still counts it.
    always_comb begin
        w_clr     = bus.clear_pulse;
        w_count   = !bus.adj && (r_state == ST_RUN) && bus.tick_1hz;
        w_sec_inc = 1'b0;
        w_min_inc = 1'b0;
        if (bus.adj) begin
            w_sec_inc = bus.tick_2hz && bus.sel;
            w_min_inc = bus.tick_2hz && !bus.sel;
        end else begin
            w_sec_inc = w_count;
            w_min_inc = w_count && w_sec_at_max;
        end
    end

    wrap_counter #(.W(CNT_W)) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_sec_inc),
        .max    (CNT_W'(MAX_SEC)),
        .value  (w_sec),
        .at_max (w_sec_at_max)
    );

    wrap_counter #(.W(CNT_W)) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_min_inc),
        .max    (CNT_W'(MAX_MIN)),
        .value  (w_min),
        .at_max (w_min_at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= !w_clr && w_count && w_sec_at_max && w_min_at_max;
        end
    end

    assign bus.min      = w_min;
    assign bus.sec      = w_sec;
    assign bus.running  = (r_state == ST_RUN);
    assign bus.rollover = r_rollover;

endmodule
